// File: rtl/mem_burst_pkg.sv
// mem_burst_pkg
// Shared definitions for the memory burst controller: FSM state encoding
// and default parameter values used by mem_burst_ctrl and its watchdog.
package mem_burst_pkg;

    localparam int ADDR_W_DEF  = 8;
    localparam int LEN_W_DEF   = 4;
    localparam int TIMEOUT_DEF = 16;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_READ_MEM    = 3'd1,
        S_SAMPLE_XFER = 3'd2,
        S_WRITE_MEM   = 3'd3,
        S_DONE        = 3'd4
    } state_e;

endpackage

// File: rtl/mem_burst_watchdog.sv
// mem_burst_watchdog
// Counts consecutive cycles spent waiting on MemReady in a memory state.
// Ports:
//   Clk, Reset  clock, asynchronous active-high reset
//   Arm_i       controller is in READ_MEM or WRITE_MEM
//   Kick_i      MemReady: the current beat completed, restart the count
//   Expired_o   combinational: this is the TIMEOUT-th cycle without MemReady
module mem_burst_watchdog
    import mem_burst_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Arm_i,
    input  logic Kick_i,
    output logic Expired_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign Expired_o = Arm_i && !Kick_i && (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        // Leaving the memory states, completing a beat or firing all restart the count.
        if (!Arm_i || Kick_i || Expired_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_burst_ctrl.sv
// mem_burst_ctrl
// Memory burst controller. A command accepted in IDLE runs a read burst
// (READ_MEM -> SAMPLE_XFER per beat), a write burst (WRITE_MEM per beat) or a
// single direct sample/transfer beat, then spends one cycle in DONE.
// Outputs are decoded from the registered state plus the registered address.
// Optional feature: define MEM_TIMEOUT_EN to add a MemReady watchdog that
// aborts the command with a one-cycle CmdError pulse after TIMEOUT cycles.
// Ports:
//   Clk, Reset                  clock, asynchronous active-high reset
//   ValidCmd, RW, Mode          command strobe / write / memory-burst select
//   Active                      block enable; low aborts any command
//   CmdAddr, CmdLen             start address, beats minus one
//   MemReady, TransferDone      memory access / serial transfer complete
//   AccessMem, RWMem, MemAddr   memory request, write select, beat address
//   SampleData, TransferData    sample and shift the current beat
//   Busy, CmdDone, CmdError     status and completion pulses
module mem_burst_ctrl
    import mem_burst_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int LEN_W   = LEN_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              ValidCmd,
    input  logic              RW,
    input  logic              Mode,
    input  logic              Active,
    input  logic [ADDR_W-1:0] CmdAddr,
    input  logic [LEN_W-1:0]  CmdLen,
    input  logic              MemReady,
    input  logic              TransferDone,
    output logic              AccessMem,
    output logic              RWMem,
    output logic [ADDR_W-1:0] MemAddr,
    output logic              SampleData,
    output logic              TransferData,
    output logic              Busy,
    output logic              CmdDone,
    output logic              CmdError
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              mode_q, mode_d;
    logic              timeout;

`ifdef MEM_TIMEOUT_EN
    logic err_q;

    mem_burst_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .Clk       (Clk),
        .Reset     (Reset),
        .Arm_i     ((state_q == S_READ_MEM) || (state_q == S_WRITE_MEM)),
        .Kick_i    (MemReady),
        .Expired_o (timeout)
    );

    // An abort (Active low) wins over a timeout, so the error needs Active.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= timeout && Active;
        end
    end

    assign CmdError = err_q;
`else
    logic unused_timeout;

    assign timeout        = 1'b0;
    assign unused_timeout = |TIMEOUT;
    assign CmdError       = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        if (state_q == S_IDLE) begin
            if (ValidCmd && Active) begin
                addr_d  = CmdAddr;
                cnt_d   = CmdLen;
                mode_d  = Mode;
                state_d = !Mode ? S_SAMPLE_XFER : (RW ? S_WRITE_MEM : S_READ_MEM);
            end
        end else if (!Active) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_READ_MEM: begin
                    if (timeout) begin
                        state_d = S_IDLE;
                    end else if (MemReady) begin
                        state_d = S_SAMPLE_XFER;
                    end
                end
                S_SAMPLE_XFER: begin
                    if (TransferDone) begin
                        // Direct (Mode=0) commands always finish after one beat.
                        if (mode_q && (cnt_q != '0)) begin
                            addr_d  = addr_q + 1'b1;
                            cnt_d   = cnt_q - 1'b1;
                            state_d = S_READ_MEM;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_WRITE_MEM: begin
                    if (timeout) begin
                        state_d = S_IDLE;
                    end else if (MemReady) begin
                        if (cnt_q != '0) begin
                            addr_d = addr_q + 1'b1;
                            cnt_d  = cnt_q - 1'b1;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    assign AccessMem    = (state_q == S_READ_MEM) || (state_q == S_WRITE_MEM);
    assign RWMem        = (state_q == S_WRITE_MEM);
    assign SampleData   = (state_q == S_SAMPLE_XFER);
    assign TransferData = (state_q == S_SAMPLE_XFER);
    assign Busy         = (state_q != S_IDLE);
    assign CmdDone      = (state_q == S_DONE);
    assign MemAddr      = addr_q;

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// tb_mem_burst_ctrl
// Directed scenarios followed by random traffic, each cycle compared against
// a transaction-level model that tracks burst phase, beat index and start
// address (expected MemAddr = start + beat index, modulo 2^ADDR_W).
module tb_mem_burst_ctrl;

    localparam int ADDR_W  = 8;
    localparam int LEN_W   = 4;
    localparam int TIMEOUT = 16;
    localparam int OW      = 7 + ADDR_W;

    localparam int P_IDLE = 0, P_RD = 1, P_XF = 2, P_WR = 3, P_DONE = 4;

    logic              Clk = 1'b0;
    logic              Reset = 1'b1;
    logic              ValidCmd = 1'b0, RW = 1'b0, Mode = 1'b0, Active = 1'b1;
    logic [ADDR_W-1:0] CmdAddr = '0;
    logic [LEN_W-1:0]  CmdLen = '0;
    logic              MemReady = 1'b0, TransferDone = 1'b0;
    logic              AccessMem, RWMem, SampleData, TransferData, Busy, CmdDone, CmdError;
    logic [ADDR_W-1:0] MemAddr;

    mem_burst_ctrl #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
        .Clk(Clk), .Reset(Reset), .ValidCmd(ValidCmd), .RW(RW), .Mode(Mode),
        .Active(Active), .CmdAddr(CmdAddr), .CmdLen(CmdLen), .MemReady(MemReady),
        .TransferDone(TransferDone), .AccessMem(AccessMem), .RWMem(RWMem),
        .MemAddr(MemAddr), .SampleData(SampleData), .TransferData(TransferData),
        .Busy(Busy), .CmdDone(CmdDone), .CmdError(CmdError)
    );

    always #5 Clk = ~Clk;

    int n_chk = 0, n_err = 0;
    int n_done = 0, n_samp = 0, n_acc = 0, n_errp = 0;
    string cur_tag = "reset";

    // Reference model state
    int                m_ph = P_IDLE, m_k = 0, m_beats = 0, m_w = 0;
    logic [ADDR_W-1:0] m_base = '0;
    bit                m_err = 1'b0;

    logic [OW-1:0] obs;
    assign obs = {AccessMem, RWMem, SampleData, TransferData, Busy, CmdDone, CmdError, MemAddr};

    function automatic logic [OW-1:0] expected();
        logic [ADDR_W-1:0] a;
        a = m_base + ADDR_W'(m_k);
        return {m_ph == P_RD || m_ph == P_WR, m_ph == P_WR, m_ph == P_XF, m_ph == P_XF,
                m_ph != P_IDLE, m_ph == P_DONE, m_err, a};
    endfunction

    task automatic check(input string tag, input logic [OW-1:0] o, input logic [OW-1:0] e);
        n_chk++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic model_reset();
        m_ph = P_IDLE; m_k = 0; m_beats = 0; m_w = 0; m_base = '0; m_err = 1'b0;
    endtask

    // Applies the burst rules to the inputs present at this clock edge.
    task automatic model_step();
        bit err_n;
        err_n = 1'b0;
        if (m_ph == P_IDLE) begin
            if (ValidCmd && Active) begin
                m_base  = CmdAddr;
                m_k     = 0;
                m_w     = 0;
                m_beats = Mode ? int'(CmdLen) + 1 : 1;
                m_ph    = !Mode ? P_XF : (RW ? P_WR : P_RD);
            end
        end else if (!Active) begin
            m_ph = P_IDLE;
        end else begin
            case (m_ph)
                P_RD, P_WR: begin
                    if (MemReady) begin
                        m_w = 0;
                        if (m_ph == P_RD) m_ph = P_XF;
                        else if (m_k + 1 < m_beats) m_k++;
                        else m_ph = P_DONE;
                    end else begin
                        m_w++;
`ifdef MEM_TIMEOUT_EN
                        if (m_w == TIMEOUT) begin
                            m_ph  = P_IDLE;
                            err_n = 1'b1;
                        end
`endif
                    end
                end
                P_XF: begin
                    if (TransferDone) begin
                        if (m_k + 1 < m_beats) begin
                            m_k++;
                            m_w  = 0;
                            m_ph = P_RD;
                        end else begin
                            m_ph = P_DONE;
                        end
                    end
                end
                default: m_ph = P_IDLE;
            endcase
        end
        m_err = err_n;
    endtask

    task automatic tick();
        @(posedge Clk);
        if (Reset) model_reset();
        else model_step();
        #1;
        check(cur_tag, obs, expected());
        if (CmdDone === 1'b1) n_done++;
        if (SampleData === 1'b1) n_samp++;
        if (AccessMem === 1'b1) n_acc++;
        if (CmdError === 1'b1) n_errp++;
    endtask

    task automatic clear_stats();
        n_done = 0; n_samp = 0; n_acc = 0; n_errp = 0;
    endtask

    // Responder: MemReady after `delay` waiting cycles, TransferDone at once.
    task automatic auto_resp(input int delay);
        MemReady     = ((m_ph == P_RD) || (m_ph == P_WR)) && (m_w >= delay);
        TransferDone = (m_ph == P_XF);
    endtask

    task automatic issue(input logic rw, input logic mode, input logic [ADDR_W-1:0] a,
                         input logic [LEN_W-1:0] len);
        ValidCmd = 1'b1; RW = rw; Mode = mode; CmdAddr = a; CmdLen = len;
        MemReady = 1'b0; TransferDone = 1'b0;
        tick();
        ValidCmd = 1'b0;
    endtask

    task automatic run_to_idle(input int delay, input int max_cyc);
        for (int c = 0; c < max_cyc; c++) begin
            auto_resp(delay);
            tick();
            if (m_ph == P_IDLE) break;
        end
        MemReady = 1'b0; TransferDone = 1'b0;
        check({cur_tag, " idle"}, OW'(Busy), OW'(0));
    endtask

    initial begin
        // Reset state, checked while Reset is held and before any clock edge
        #2;
        check("reset", obs, '0);
        @(negedge Clk);
        Reset = 1'b0;
        cur_tag = "idle";
        tick();
        tick();

        // Read burst 0x10, 3 beats, MemReady one cycle late
        cur_tag = "read_burst";
        clear_stats();
        issue(1'b0, 1'b1, 8'h10, 4'd2);
        run_to_idle(1, 40);
        check("read_burst done_cnt", OW'(n_done), OW'(1));
        check("read_burst samp_cnt", OW'(n_samp), OW'(3));
        check("read_burst acc_cnt",  OW'(n_acc),  OW'(6));

        // Write burst 0xFF, 2 beats: address wraps to 0x00
        cur_tag = "write_wrap";
        clear_stats();
        issue(1'b1, 1'b1, 8'hFF, 4'd1);
        check("write_wrap first_addr", OW'(MemAddr), OW'(8'hFF));
        run_to_idle(1, 40);
        check("write_wrap last_addr", OW'(MemAddr), OW'(8'h00));
        check("write_wrap done_cnt", OW'(n_done), OW'(1));
        check("write_wrap acc_cnt",  OW'(n_acc),  OW'(4));

        // Direct mode ignores CmdLen: one beat, never touches memory
        cur_tag = "direct";
        clear_stats();
        issue(1'b0, 1'b0, 8'h33, 4'd7);
        run_to_idle(0, 20);
        check("direct samp_cnt", OW'(n_samp), OW'(1));
        check("direct acc_cnt",  OW'(n_acc),  OW'(0));
        check("direct done_cnt", OW'(n_done), OW'(1));

        // Abort in the second read beat; a ValidCmd while busy is ignored
        cur_tag = "abort";
        clear_stats();
        issue(1'b0, 1'b1, 8'h40, 4'd3);
        ValidCmd = 1'b1; RW = 1'b1; CmdAddr = 8'h99;
        for (int c = 0; c < 30; c++) begin
            if (m_ph == P_RD && m_k == 1) break;
            auto_resp(2);
            tick();
            ValidCmd = 1'b0;
        end
        ValidCmd = 1'b0; MemReady = 1'b0; TransferDone = 1'b0;
        check("abort in_beat2", OW'(MemAddr), OW'(8'h41));
        Active = 1'b0;
        tick();
        check("abort busy", OW'(Busy), OW'(0));
        check("abort done_cnt", OW'(n_done), OW'(0));
        Active = 1'b1;
        tick();

        // MemReady held low
        cur_tag = "timeout";
        clear_stats();
        issue(1'b0, 1'b1, 8'h20, 4'd0);
        repeat (TIMEOUT + 4) tick();
`ifdef MEM_TIMEOUT_EN
        check("timeout err_cnt", OW'(n_errp), OW'(1));
        check("timeout busy", OW'(Busy), OW'(0));
`else
        check("timeout err_cnt", OW'(n_errp), OW'(0));
        check("timeout still_rd", OW'({Busy, AccessMem}), OW'(2'b11));
        Active = 1'b0;
        tick();
        Active = 1'b1;
`endif
        check("timeout done_cnt", OW'(n_done), OW'(0));

        // Asynchronous reset in the middle of a write burst
        cur_tag = "reset_mid";
        issue(1'b1, 1'b1, 8'h80, 4'd5);
        auto_resp(0);
        tick();
        tick();
        #2;
        Reset = 1'b1;
        #1;
        check("reset_mid async", obs, '0);
        model_reset();
        tick();
        @(negedge Clk);
        Reset = 1'b0;
        MemReady = 1'b0;
        tick();

        // Random traffic against the model
        cur_tag = "random";
        for (int c = 0; c < 600; c++) begin
            ValidCmd     = ($urandom_range(0, 99) < 30);
            RW           = 1'($urandom);
            Mode         = ($urandom_range(0, 99) < 70);
            Active       = ($urandom_range(0, 99) < 95);
            CmdAddr      = ADDR_W'($urandom);
            CmdLen       = LEN_W'($urandom);
            MemReady     = ($urandom_range(0, 99) < 35);
            TransferDone = ($urandom_range(0, 99) < 40);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
